// File: rtl/elastic_pipeline_reg.sv
// Elastic pipeline stage register: main entry plus one skid entry, valid/ready both sides.
// Optional stall counter port stall_cycles enabled by `define ELASTIC_PIPE_STATS_EN.
module elastic_pipeline_reg #(
    parameter int DATA_WIDTH = 96,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef ELASTIC_PIPE_STATS_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    logic                  main_valid_q, main_valid_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  acc_in;
    logic                  acc_out;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign acc_in    = in_valid & ~skid_valid_q;
    assign acc_out   = main_valid_q & out_ready;

    // Next-state: main refills from skid first (older), then from input.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_ctrl_d  = '0;
        end else begin
            if (~main_valid_q | acc_out) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = skid_ctrl_q;
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end else if (acc_in) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = in_ctrl;
                    main_data_d  = in_data;
                end else begin
                    main_valid_d = 1'b0;
                end
            end
            if (acc_in & main_valid_q & ~out_ready) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end
        end
    end

    // Stage registers with synchronous reset overriding everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef ELASTIC_PIPE_STATS_EN
    logic [15:0] stall_q, stall_d;

    assign stall_cycles = stall_q;

    // Saturating count of cycles with a valid output held back downstream.
    always_comb begin
        stall_d = stall_q;
        if (main_valid_q & ~out_ready & (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_elastic_pipeline_reg.sv
// Testbench for elastic_pipeline_reg: directed scenarios plus random traffic
// checked against a 2-deep FIFO reference model.
module tb_elastic_pipeline_reg;

    localparam int DW = 96;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef ELASTIC_PIPE_STATS_EN
    logic [15:0]   stall_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;

    elastic_pipeline_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ctrl(in_ctrl),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl(out_ctrl),
        .out_data(out_data)
`ifdef ELASTIC_PIPE_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] last_d = '0;
    int            m_stall = 0;
    logic          e_valid, e_ready;
    logic [CW-1:0] e_ctrl;
    logic [DW-1:0] e_data;

    // Advance one clock; model is a FIFO of capacity two.
    task automatic tick();
        bit   ai, ao;
        ent_t e;
        ai = in_valid && (q.size() < 2);
        ao = (q.size() > 0) && out_ready;
        e.c = in_ctrl;
        e.d = in_data;
        if (reset) m_stall = 0;
        else if (q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
        @(posedge clock);
        if (reset) begin
            q.delete();
            last_d = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (ao) void'(q.pop_front());
            if (ai) q.push_back(e);
        end
        if (q.size() > 0) last_d = q[0].d;
        e_valid = (q.size() > 0);
        e_ctrl  = e_valid ? q[0].c : '0;
        e_data  = last_d;
        e_ready = (q.size() < 2);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic idle();
        flush = 0; in_valid = 0; out_ready = 0;
        in_ctrl = '0; in_data = '0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); in_valid = 1;
        in_ctrl = 8'hFF; in_data = rnd96();
        tick(); tick();
        reset = 0; in_valid = 0;
        vectors++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: v=%b c=%h d=%h rdy=%b, need 0 0 0 1",
                     out_valid, out_ctrl, out_data, in_ready);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_ctrl = 8'h03; in_data = DW'(i);
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_ctrl !== 8'h03 || out_data !== DW'(i) || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream[%0d]: v=%b c=%h d=%0d rdy=%b, need 1 03 %0d 1",
                         i, out_valid, out_ctrl, out_data, in_ready, i);
            end
        end
        in_valid = 0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== DW'(8)) begin
            miscompares++;
            $display("FAIL stream_drain: v=%b d=%0d, need 0 8", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a, b, c;
        a = rnd96(); b = rnd96(); c = rnd96();
        out_ready = 0;
        in_valid = 1; in_ctrl = 8'h11; in_data = a; tick();
        in_ctrl = 8'h22; in_data = b; tick();
        in_ctrl = 8'h33; in_data = c;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== a || out_ctrl !== 8'h11 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_full[%0d]: v=%b c=%h rdy=%b d=%h, need 1 11 0 %h",
                         k, out_valid, out_ctrl, in_ready, out_data, a);
            end
        end
        out_ready = 1;
        tick();
        vectors++;
        if (out_data !== b || out_ctrl !== 8'h22 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_B: d=%h c=%h rdy=%b, need %h 22 1", out_data, out_ctrl, in_ready, b);
        end
        tick();
        in_valid = 0;
        vectors++;
        if (out_data !== c || out_ctrl !== 8'h33 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_C: d=%h c=%h v=%b, need %h 33 1", out_data, out_ctrl, out_valid, c);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_dup: v=%b, need 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1;
        in_ctrl = 8'hA1; in_data = rnd96(); tick();
        in_ctrl = 8'hB2; in_data = rnd96(); tick();
        in_ctrl = 8'hC3; in_data = rnd96();
        flush = 1; tick();
        flush = 0; in_valid = 0; out_ready = 1;
        vectors++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush: v=%b c=%h rdy=%b, need 0 00 1", out_valid, out_ctrl, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0 || out_ctrl !== '0) begin
                miscompares++;
                $display("FAIL flush_leak[%0d]: v=%b c=%h, need 0 00", k, out_valid, out_ctrl);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b;
        a = rnd96(); b = rnd96();
        out_ready = 0; in_valid = 1; in_ctrl = 8'h5A; in_data = a; tick();
        out_ready = 1; in_ctrl = 8'hA5; in_data = b; tick();
        in_valid = 0; out_ready = 0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== b || out_ctrl !== 8'hA5 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b: v=%b d=%h c=%h rdy=%b, need 1 %h A5 1",
                     out_valid, out_data, out_ctrl, in_ready, b);
        end
        out_ready = 1; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_ctrl  = 8'($urandom);
                in_data  = rnd96();
            end
            tick();
            vectors++;
            if (out_valid !== e_valid || out_ctrl !== e_ctrl || out_data !== e_data || in_ready !== e_ready) begin
                miscompares++;
                $display("FAIL random[%0d]: v=%b c=%h d=%h rdy=%b, need %b %h %h %b",
                         i, out_valid, out_ctrl, out_data, in_ready, e_valid, e_ctrl, e_data, e_ready);
            end
`ifdef ELASTIC_PIPE_STATS_EN
            if (stall_cycles !== 16'(m_stall)) begin
                miscompares++;
                $display("FAIL random_stall[%0d]: got %0d need %0d", i, stall_cycles, m_stall);
            end
`endif
        end
        reset = 0; idle(); out_ready = 1;
        tick(); tick(); tick();
    endtask

`ifdef ELASTIC_PIPE_STATS_EN
    task automatic test_stats();
        reset = 1; idle(); tick(); reset = 0;
        in_valid = 1; in_ctrl = 8'h01; in_data = rnd96(); tick();
        in_valid = 0;
        for (int k = 0; k < 5; k++) tick();
        vectors++;
        if (stall_cycles !== 16'd5) begin
            miscompares++;
            $display("FAIL stall5: got %0d need 5", stall_cycles);
        end
        for (int k = 0; k < 70000; k++) tick();
        vectors++;
        if (stall_cycles !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL stall_sat: got %h need FFFF", stall_cycles);
        end
        flush = 1; tick(); flush = 0;
        vectors++;
        if (stall_cycles !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL stall_flush: got %h need FFFF", stall_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
`ifdef ELASTIC_PIPE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
